// File: rtl/conv5x5_mac.sv
// 5x5 convolution MAC: loads a 5x5 signed kernel, then multiplies each incoming window
// by it, adds a bias and emits one result per legal window position (4-stage pipeline).
module conv5x5_mac #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int K     = 5,
    parameter int PIX_W = 9,
    parameter int ACC_W = 23,
    parameter int RELU  = 0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    input  logic [K*PIX_W-1:0]      x_m_1,
    input  logic [K*PIX_W-1:0]      x_m_2,
    input  logic [K*PIX_W-1:0]      x_m_3,
    input  logic [K*PIX_W-1:0]      x_m_4,
    input  logic [K*PIX_W-1:0]      x_m_5,
    input  logic                    w_we,
    input  logic signed [PIX_W-1:0] w_data,
    input  logic signed [ACC_W-1:0] bias,
    output logic                    weights_ready,
    output logic                    busy,
    output logic                    out_valid,
    output logic signed [ACC_W-1:0] out_data,
    output logic                    done
);
    localparam int NW = K * K;
    localparam int PW = 2 * PIX_W;
    localparam int SW = PW + 3;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int IW = $clog2(NW);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_LEGAL = CW'(K - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NW - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]              state;
    logic [IW-1:0]           w_idx;
    logic signed [PIX_W-1:0] weight [NW];
    logic [CW-1:0]           col;
    logic [RW-1:0]           row;
    logic                    accept, acc_last, acc_legal;
    logic [K*PIX_W-1:0]      cols [K];
    logic signed [PIX_W-1:0] pix [NW];
    logic signed [PW-1:0]    prod [NW];
    logic signed [SW-1:0]    col_sum_d [K];
    logic signed [SW-1:0]    col_sum [K];
    logic signed [ACC_W-1:0] total_d, total;
    logic                    v1, v2, v3, l1, l2, l3;

    assign cols[0] = x_m_1;
    assign cols[1] = x_m_2;
    assign cols[2] = x_m_3;
    assign cols[3] = x_m_4;
    assign cols[4] = x_m_5;

    // in_valid is a valid-only strobe with no backpressure: a window is taken on every
    // edge where in_valid=1 and the FSM can accept (IDLE with weights loaded, or RUN).
    assign accept    = in_valid && ((state == S_IDLE && weights_ready) || state == S_RUN);
    assign acc_last  = (row == ROW_LAST) && (col == COL_LAST);
    assign acc_legal = (col >= COL_LEGAL);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_idx         <= '0;
            weights_ready <= 1'b0;
            for (int k = 0; k < NW; k++) weight[k] <= '0;
        end else if (w_we && state == S_IDLE) begin
            weight[w_idx] <= w_data;
            if (w_idx == IDX_LAST) begin
                w_idx         <= '0;
                weights_ready <= 1'b1;
            end else begin
                w_idx <= w_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
            col   <= '0;
            row   <= ROW_FIRST;
        end else begin
            if (accept) begin
                if (acc_last) begin
                    col <= '0;
                    row <= ROW_FIRST;
                end else if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            case (state)
                S_IDLE:  if (accept) state <= acc_last ? S_FLUSH : S_RUN;
                S_RUN:   if (accept && acc_last) state <= S_FLUSH;
                S_FLUSH: if (done) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Column bits [44:36] hold the top row, so row r sits at slice (K-1-r).
    always_comb begin
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                pix[r*K+c] = cols[c][(K-1-r)*PIX_W +: PIX_W];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1 <= 1'b0;
            l1 <= 1'b0;
            for (int k = 0; k < NW; k++) prod[k] <= '0;
        end else begin
            v1 <= accept && acc_legal;
            l1 <= accept && acc_last;
            if (accept)
                for (int k = 0; k < NW; k++) prod[k] <= pix[k] * weight[k];
        end
    end

    always_comb begin
        for (int c = 0; c < K; c++) begin
            col_sum_d[c] = '0;
            for (int r = 0; r < K; r++)
                col_sum_d[c] = col_sum_d[c] + SW'(prod[r*K+c]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v2 <= 1'b0;
            l2 <= 1'b0;
            for (int c = 0; c < K; c++) col_sum[c] <= '0;
        end else begin
            v2 <= v1;
            l2 <= l1;
            if (v1)
                for (int c = 0; c < K; c++) col_sum[c] <= col_sum_d[c];
        end
    end

    always_comb begin
        total_d = bias;
        for (int c = 0; c < K; c++)
            total_d = total_d + ACC_W'(col_sum[c]);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v3    <= 1'b0;
            l3    <= 1'b0;
            total <= '0;
        end else begin
            v3 <= v2;
            l3 <= l2;
            if (v2) total <= total_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            out_valid <= v3;
            done      <= v3 && l3;
            if (v3) out_data <= ((RELU != 0) && (total < 0)) ? '0 : total;
        end
    end
endmodule

// File: tb/tb_conv5x5_mac.sv
// Bench for conv5x5_mac: drives frames of windows, predicts each result from the kernel
// and pixels it drove, and compares against two instances (plain and RELU=1).
module tb_conv5x5_mac;
    localparam int IMG_W = 28;
    localparam int IMG_H = 28;
    localparam int K     = 5;
    localparam int PIX_W = 9;
    localparam int ACC_W = 23;
    localparam int NPOS  = (IMG_W - K + 1) * (IMG_H - K + 1);

    logic                    clk = 1'b0;
    logic                    rstn = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    w_we = 1'b0;
    logic signed [PIX_W-1:0] w_data = '0;
    logic signed [ACC_W-1:0] bias = '0;
    logic [K*PIX_W-1:0]      xc [K];
    logic [K*PIX_W-1:0]      x_m_1, x_m_2, x_m_3, x_m_4, x_m_5;

    logic                    weights_ready, busy, out_valid, done;
    logic signed [ACC_W-1:0] out_data;
    logic                    r_weights_ready, r_busy, r_out_valid, r_done;
    logic signed [ACC_W-1:0] r_out_data;

    assign x_m_1 = xc[0];
    assign x_m_2 = xc[1];
    assign x_m_3 = xc[2];
    assign x_m_4 = xc[3];
    assign x_m_5 = xc[4];

    conv5x5_mac #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .PIX_W(PIX_W), .ACC_W(ACC_W), .RELU(0)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid),
        .x_m_1(x_m_1), .x_m_2(x_m_2), .x_m_3(x_m_3), .x_m_4(x_m_4), .x_m_5(x_m_5),
        .w_we(w_we), .w_data(w_data), .bias(bias),
        .weights_ready(weights_ready), .busy(busy), .out_valid(out_valid),
        .out_data(out_data), .done(done)
    );

    conv5x5_mac #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .PIX_W(PIX_W), .ACC_W(ACC_W), .RELU(1)) dut_relu (
        .clk(clk), .rstn(rstn), .in_valid(in_valid),
        .x_m_1(x_m_1), .x_m_2(x_m_2), .x_m_3(x_m_3), .x_m_4(x_m_4), .x_m_5(x_m_5),
        .w_we(w_we), .w_data(w_data), .bias(bias),
        .weights_ready(r_weights_ready), .busy(r_busy), .out_valid(r_out_valid),
        .out_data(r_out_data), .done(r_done)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    logic [ACC_W-1:0] exp_q[$];
    logic [ACC_W-1:0] exp_r_q[$];
    logic [ACC_W-1:0] e_main, e_relu;
    int checks = 0;
    int errors = 0;
    int n_out, n_valid, fifth_cyc, first_out_cyc;
    bit frame_done;

    // reference model state
    int w_m [K*K];
    int wset [K*K];
    int idx_m, ready_m, bias_m;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            n_out++;
            if (first_out_cyc < 0) first_out_cyc = cyc;
            check_eq("q_avail", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e_main = exp_q.pop_front();
                check_eq("out_data", int'(out_data), int'($signed(e_main)));
            end
        end
        if (r_out_valid) begin
            check_eq("relu_q_avail", int'(exp_r_q.size() > 0), 1);
            if (exp_r_q.size() > 0) begin
                e_relu = exp_r_q.pop_front();
                check_eq("relu_out_data", int'(r_out_data), int'($signed(e_relu)));
            end
        end
        if (done) begin
            check_eq("done_valid", int'(out_valid), 1);
            check_eq("done_count", n_out, NPOS);
            check_eq("done_q_empty", exp_q.size(), 0);
            frame_done = 1'b1;
        end
    end

    // driver tasks
    task automatic model_reset();
        for (int k = 0; k < K*K; k++) w_m[k] = 0;
        idx_m   = 0;
        ready_m = 0;
    endtask

    function automatic int model_sum();
        int s;
        s = bias_m;
        for (int c = 0; c < K; c++)
            for (int r = 0; r < K; r++)
                s += w_m[r*K+c] * int'($signed(xc[c][(K-1-r)*PIX_W +: PIX_W]));
        return s;
    endfunction

    task automatic set_pixels(input int mode, input int cval);
        for (int c = 0; c < K; c++)
            for (int r = 0; r < K; r++) begin
                int v;
                case (mode)
                    0:       v = cval;
                    1:       v = r*5 + c;
                    default: v = int'($urandom_range(0, 511));
                endcase
                xc[c][(K-1-r)*PIX_W +: PIX_W] = PIX_W'(v);
            end
    endtask

    task automatic load_w(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            w_we   = 1'b1;
            w_data = PIX_W'(wset[idx_m]);
            w_m[idx_m] = wset[idx_m];
            if (idx_m == K*K - 1) begin
                idx_m   = 0;
                ready_m = 1;
            end else begin
                idx_m++;
            end
        end
        @(negedge clk);
        w_we = 1'b0;
        check_eq("w_ready", int'(weights_ready), ready_m);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            w_we     = 1'b0;
            set_pixels(2, 0);
        end
    endtask

    task automatic drive_window(input int mode, input int cval, input int row, input int col, input bit junk);
        int s;
        @(negedge clk);
        if (row == 6 && col == 0) check_eq("busy_run", int'(busy), 1);
        set_pixels(mode, cval);
        in_valid = 1'b1;
        w_we     = junk && (row > K-1) && ($urandom_range(0, 3) == 0);
        w_data   = PIX_W'($urandom_range(0, 511));
        n_valid++;
        if (n_valid == 5) fifth_cyc = cyc;
        if (col >= K-1) begin
            s = model_sum();
            exp_q.push_back(ACC_W'(s));
            exp_r_q.push_back(s < 0 ? '0 : ACC_W'(s));
        end
    endtask

    task automatic abort_frame();
        @(negedge clk);
        #2 rstn = 1'b0;
        in_valid = 1'b0;
        w_we     = 1'b0;
        #1;
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_w_ready", int'(weights_ready), 0);
        check_eq("rst_done", int'(done), 0);
        exp_q.delete();
        exp_r_q.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        model_reset();
    endtask

    task automatic run_frame(input int mode, input int cval, input bit gaps, input bit junk, input int abort_at);
        n_out         = 0;
        n_valid       = 0;
        frame_done    = 1'b0;
        first_out_cyc = -1;
        bias_m        = int'(bias);
        for (int row = K-1; row < IMG_H; row++)
            for (int col = 0; col < IMG_W; col++) begin
                if (abort_at > 0 && n_valid == abort_at) begin
                    abort_frame();
                    return;
                end
                if (row == 10 && col == 13) idle_cycles(3);
                else if (gaps && $urandom_range(0, 11) == 0) idle_cycles(int'($urandom_range(1, 3)));
                drive_window(mode, cval, row, col, junk);
            end
        // trailing windows arrive while the frame drains and must be dropped
        repeat (2) begin
            @(negedge clk);
            in_valid = 1'b1;
            w_we     = 1'b0;
            set_pixels(2, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 300 && !frame_done; i++) @(negedge clk);
        check_eq("frame_done", int'(frame_done), 1);
        check_eq("frame_count", n_out, NPOS);
        check_eq("latency", first_out_cyc - fifth_cyc, 4);
        @(negedge clk);
        check_eq("busy_after", int'(busy), 0);
        check_eq("q_drained", exp_q.size() + exp_r_q.size(), 0);
    endtask

    initial begin
        for (int c = 0; c < K; c++) xc[c] = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check_eq("reset_out_valid", int'(out_valid), 0);
        check_eq("reset_out_data", int'(out_data), 0);
        check_eq("reset_done", int'(done), 0);
        check_eq("reset_busy", int'(busy), 0);
        check_eq("reset_w_ready", int'(weights_ready), 0);

        // centre tap only, constant pixels
        for (int k = 0; k < K*K; k++) wset[k] = (k == 12) ? 1 : 0;
        load_w(K*K);
        bias = '0;
        run_frame(0, 3, 1'b0, 1'b0, 0);

        // all-ones kernel, negative biases (RELU instance clamps the second)
        for (int k = 0; k < K*K; k++) wset[k] = 1;
        load_w(K*K);
        bias = -23'sd10;
        run_frame(0, 2, 1'b0, 1'b0, 0);
        bias = -23'sd100;
        run_frame(0, 2, 1'b0, 1'b0, 0);

        // ramp kernel against ramp pixels, with bubbles
        for (int k = 0; k < K*K; k++) wset[k] = k - 12;
        load_w(K*K);
        bias = '0;
        run_frame(1, 0, 1'b1, 1'b0, 0);

        // random pixels with stray weight writes during the frame
        bias = 23'sd37;
        run_frame(2, 0, 1'b1, 1'b1, 0);

        // incomplete kernel load keeps the block idle
        @(negedge clk);
        rstn = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < K*K; k++) wset[k] = int'($urandom_range(0, 511)) - 256;
        load_w(K*K - 1);
        n_out = 0;
        repeat (10) begin
            @(negedge clk);
            in_valid = 1'b1;
            set_pixels(2, 0);
        end
        idle_cycles(6);
        check_eq("idle_busy", int'(busy), 0);
        check_eq("idle_no_out", n_out, 0);
        load_w(1);
        bias = -23'sd5000;
        run_frame(2, 0, 1'b1, 1'b0, 0);

        // reset mid-frame, then a full frame after reloading
        run_frame(1, 0, 1'b0, 1'b0, 100);
        for (int k = 0; k < K*K; k++) wset[k] = int'($urandom_range(0, 511)) - 256;
        load_w(K*K);
        bias = 23'sd1234;
        run_frame(2, 0, 1'b1, 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
